// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring-divide unit that owns the HI/LO pair.
// Latency: 34 edges (capture, 32 iterations, sign-fix); done pulses with new HI/LO.
// Backpressure: busy holds off start/mthi/mtlo; those inputs are ignored while busy.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start, op, a, b launch mult(00)/multu(01)/div(10)/divu(11) on rs=a, rt=b
//   hi_wr, lo_wr    mthi/mtlo strobes loading wdata while idle
//   busy, done      in-progress stall flag, one-cycle result pulse
//   hi, lo          registered HI/LO
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  // neg_lo: product sign (mult) or quotient sign (div); neg_hi: remainder sign.
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  // acc_hi/acc_lo: product upper/lower during multiply, remainder/quotient during divide.
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_diff;
  logic             div_ok;
  logic [PW-1:0]    prod, prod_fix;

  // Signed ops are the even opcodes (mult, div).
  assign a_neg = ~op[0] & a[WIDTH-1];
  assign b_neg = ~op[0] & b[WIDTH-1];
  assign a_mag = a_neg ? (~a + WIDTH'(1)) : a;
  assign b_mag = b_neg ? (~b + WIDTH'(1)) : b;

  // Multiply step: conditional add keeps its carry in bit WIDTH, which becomes the new MSB after the shift.
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);

  // Divide step: since remainder < divisor is invariant, the shifted remainder is below 2*divisor,
  // so a WIDTH+1 bit subtract leaves bit WIDTH set exactly when the trial goes negative.
  assign div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opnd_q};
  assign div_ok   = ~div_diff[WIDTH];

  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = neg_lo_q ? (~prod + PW'(1)) : prod;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          // start takes priority; a coincident mthi/mtlo is dropped.
          is_div_d = op[1];
          cnt_d    = '0;
          acc_hi_d = '0;
          state_d  = CALC;
          if (op[1]) begin
            // Divide by zero keeps an all-ones quotient for signed ops too,
            // so the quotient is never negated when the divisor is zero.
            neg_lo_d = (a_neg ^ b_neg) & (|b);
            neg_hi_d = a_neg;
            acc_lo_d = a_mag;
            opnd_d   = b_mag;
          end else begin
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = 1'b0;
            acc_lo_d = b_mag;
            opnd_d   = a_mag;
          end
        end else begin
          if (hi_wr) hi_d = wdata;
          if (lo_wr) lo_d = wdata;
        end
      end

      CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (is_div_q) begin
          acc_hi_d = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ok};
        end else begin
          acc_hi_d = mul_sum[WIDTH:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end

      FIX: begin
        if (is_div_q) begin
          lo_d = neg_lo_q ? (~acc_lo_q + WIDTH'(1)) : acc_lo_q;
          hi_d = neg_hi_q ? (~acc_hi_q + WIDTH'(1)) : acc_hi_q;
        end else begin
          hi_d = prod_fix[PW-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected {HI,LO}, a monitor pops on done.
// Latency, busy length and mthi/mtlo/reset behaviour are checked inline by the stimulus thread.
// Inputs change 1ns after the rising edge; outputs are read then or on the falling edge.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        hi_wr, lo_wr;
  logic        busy, done;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hi_wr(hi_wr), .lo_wr(lo_wr), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_done: got hi=%h lo=%h expected no result", hi, lo);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("sb_hi", hi, e[63:32]);
        chk("sb_lo", lo, e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called 1ns after a rising edge; returns 1ns after capture edge E0.
  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit push, input logic [31:0] eh, input logic [31:0] el);
    int guard = 0;
    while (busy && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    start = 1'b1; op = o; a = x; b = y;
    if (push) exp_q.push_back({eh, el});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges until done is seen; bc counts busy cycles from the current one.
  task automatic wait_done(output int n, output int bc);
    n  = 0;
    bc = busy ? 1 : 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (!done && busy) bc++;
    end while (!done && n < 200);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
    end
  endtask

  // Full single operation with latency, busy-length and done-pulse checks.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
    int n, bc;
    start_op(o, x, y, 1'b1, eh, el);
    wait_done(n, bc);
    chk({name, "_latency"}, 32'(n), 32'd33);
    chk({name, "_busy_cycles"}, 32'(bc), 32'd33);
    chk({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk({name, "_done_one_cycle"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n, bc;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    wdata = '0; hi_wr = 1'b0; lo_wr = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed arithmetic vectors.
    run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_neg",  OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("div_neg",   OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_zero", OP_DIVU,  32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF);
    run_op("div_zero",  OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);
    run_op("div_ovf",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op("div_pos_negd", OP_DIV, 32'd100,     32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2);

    // mthi/mtlo while idle.
    hi_wr = 1'b1; lo_wr = 1'b1; wdata = 32'h0F0F0F0F;
    @(posedge clk); #1;
    hi_wr = 1'b0; lo_wr = 1'b0;
    chk("mthilo_hi", hi, 32'h0F0F0F0F);
    chk("mthilo_lo", lo, 32'h0F0F0F0F);
    hi_wr = 1'b1; wdata = 32'hAAAA5555;
    @(posedge clk); #1;
    hi_wr = 1'b0;
    chk("mthi", hi, 32'hAAAA5555);
    lo_wr = 1'b1; wdata = 32'h5555AAAA;
    @(posedge clk); #1;
    lo_wr = 1'b0;
    chk("mtlo", lo, 32'h5555AAAA);

    // divu 100/7 with a coincident mtlo (dropped) and a start+mthi at E5 (ignored).
    lo_wr = 1'b1; wdata = 32'hDEADBEEF;
    start_op(OP_DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14);
    lo_wr = 1'b0;
    chk("start_beats_mtlo", lo, 32'h5555AAAA);
    chk("hi_held_busy", hi, 32'hAAAA5555);
    repeat (4) begin
      @(posedge clk); #1;
    end
    start = 1'b1; hi_wr = 1'b1; wdata = 32'h13579BDF; op = OP_MULTU; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0; hi_wr = 1'b0;
    chk("busy_mthi_ignored", hi, 32'hAAAA5555);
    wait_done(n, bc);
    chk("divu_interf_latency", 32'(n), 32'd28);
    @(posedge clk); #1;
    chk("busy_start_ignored", {31'd0, busy}, 32'd0);

    // Asynchronous reset at E10 of a mult.
    start_op(OP_MULT, 32'd7, 32'd9, 1'b0, 32'd0, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("multu_after_rst", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12);

    // start held high: back-to-back multu 2*3 then 4*5.
    start_op(OP_MULTU, 32'd2, 32'd3, 1'b1, 32'd0, 32'd6);
    start = 1'b1; a = 32'd4; b = 32'd5;
    exp_q.push_back({32'd0, 32'd20});
    wait_done(n, bc);
    chk("b2b_first_latency", 32'(n), 32'd33);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_relaunch_busy", {31'd0, busy}, 32'd1);
    wait_done(n, bc);
    // One edge already taken above, so this is 34 cycles after the first done.
    chk("b2b_second_spacing", 32'(n + 1), 32'd34);
    @(posedge clk); #1;

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
